mrelbp_hist_readout: RTL and testbench

//  Parametrised readout arbiter for the MRELBP pipeline's NUM_CH joint histograms (one per radius).

---
 rtl/mrelbp_pkg.sv | 20 ++
 rtl/mrelbp_sync_fifo.sv | 53 +++++
 rtl/mrelbp_hist_readout.sv | 198 +++++++++++++++++++
 tb/tb_mrelbp_hist_readout.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mrelbp_pkg.sv
// MRELBP histogram readout: shared state encoding and sizing helpers.
// Imported by the readout arbiter and its output FIFO.
package mrelbp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEL,
      ST_WAIT,
      ST_READ,
      ST_FLUSH,
      ST_FIN
   } state_e;

   localparam int DEF_BINS = 200;

   function automatic int ch_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mrelbp_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A push on a full FIFO is accepted only when a pop frees the slot.
module mrelbp_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic [W-1:0]           din_i,
   input  logic                   pop_i,
   output logic [W-1:0]           dout_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   always_comb begin
      empty_o = (cnt_q == '0);
      full_o  = (cnt_q == (AW+1)'(DEPTH));
      do_pop  = pop_i && !empty_o;
      do_push = push_i && (!full_o || do_pop);
      wr_d    = wr_q + AW'(do_push);
      rd_d    = rd_q + AW'(do_pop);
      cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/mrelbp_hist_readout.sv
// Readout arbiter: drains each enabled histogram channel in ascending
// order onto an AXI4-Stream master, credit-limited by the output FIFO.
module mrelbp_hist_readout
   import mrelbp_pkg::*;
#(
   parameter  int NUM_CH     = 3,
   parameter  int DATA_W     = 32,
   parameter  int BINS       = DEF_BINS,
   parameter  int RD_LAT     = 1,
   parameter  int FIFO_DEPTH = 4,
   localparam int CH_W       = ch_w(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_i,
   input  logic [NUM_CH-1:0]        ch_en_i,
   input  logic [NUM_CH-1:0]        ch_done_i,
   output logic [NUM_CH-1:0]        ch_rd_en_o,
   input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
   input  logic [NUM_CH-1:0]        ch_valid_i,
   output logic [DATA_W-1:0]        m_axis_tdata,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic [CH_W-1:0]          m_axis_tuser,
   output logic                     busy_o,
   output logic                     irq_o,
   output logic                     err_o
);
   localparam int BIN_W = (BINS <= 1) ? 1 : $clog2(BINS);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int FW    = DATA_W + 1 + CH_W;

   state_e            state_q, state_d;
   logic [CH_W-1:0]   cur_q, cur_d;
   logic [BIN_W-1:0]  bin_q, bin_d;
   logic [NUM_CH-1:0] en_q, en_d, done_q, done_d, srv_q, srv_d;
   logic              busy_q, busy_d, irq_q, irq_d, err_q, err_d;
   logic [RD_LAT-1:0] tv_q, tv_d, tl_q, tl_d;
   logic [CH_W-1:0]   tc_q [RD_LAT];
   logic [CH_W-1:0]   tc_d [RD_LAT];

   logic              start_acc, issue, credit, tag_err;
   logic              pend_any, cur_done, x_valid;
   logic [NUM_CH-1:0] pend, cur_1h;
   logic [CH_W-1:0]   pend_ch, x_ch;
   logic [DATA_W-1:0] x_data;
   int                inflight;

   logic              f_push, f_pop, f_empty, f_full;
   logic [FW-1:0]     f_din, f_dout;
   logic [CNT_W-1:0]  f_cnt;

   always_comb begin
      start_acc = start_i && (state_q == ST_IDLE);
      pend      = en_q & ~srv_q;
      pend_any  = |pend;
      pend_ch   = '0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (pend[c]) pend_ch = CH_W'(c);
      end
      for (int c = 0; c < NUM_CH; c++) begin
         cur_1h[c] = (cur_q == CH_W'(c));
      end
      cur_done = |(done_q & cur_1h);

      // Reserve a FIFO slot for every read still in the tag pipe.
      inflight   = $countones(tv_q);
      credit     = (int'(f_cnt) + inflight) < FIFO_DEPTH;
      issue      = (state_q == ST_READ) && credit;
      ch_rd_en_o = issue ? cur_1h : '0;

      x_ch    = tc_q[RD_LAT-1];
      x_data  = '0;
      x_valid = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (x_ch == CH_W'(c)) begin
            x_data  = ch_data_i[c*DATA_W +: DATA_W];
            x_valid = ch_valid_i[c];
         end
      end
      f_push  = tv_q[RD_LAT-1];
      tag_err = f_push && !x_valid;
      f_din   = {tl_q[RD_LAT-1], x_ch, x_data};
      f_pop   = !f_empty && m_axis_tready;

      tv_d[0] = issue;
      tl_d[0] = (bin_q == BIN_W'(BINS - 1));
      tc_d[0] = cur_q;
      for (int i = 1; i < RD_LAT; i++) begin
         tv_d[i] = tv_q[i-1];
         tl_d[i] = tl_q[i-1];
         tc_d[i] = tc_q[i-1];
      end

      state_d = state_q;
      cur_d   = cur_q;
      bin_d   = bin_q;
      en_d    = en_q;
      srv_d   = srv_q;
      busy_d  = busy_q;
      irq_d   = 1'b0;
      done_d  = (start_acc ? '0 : done_q) | ch_done_i;
      err_d   = start_acc ? 1'b0 : (err_q | tag_err);

      unique case (state_q)
         ST_IDLE: if (start_i) begin
            state_d = ST_SEL;
            en_d    = ch_en_i;
            srv_d   = '0;
            busy_d  = 1'b1;
         end
         ST_SEL: if (pend_any) begin
            cur_d   = pend_ch;
            bin_d   = '0;
            state_d = ST_WAIT;
         end else begin
            state_d = ST_FLUSH;
         end
         ST_WAIT: if (cur_done) state_d = ST_READ;
         ST_READ: if (issue) begin
            if (bin_q == BIN_W'(BINS - 1)) begin
               bin_d   = '0;
               srv_d   = srv_q | cur_1h;
               state_d = ST_SEL;
            end else begin
               bin_d = bin_q + BIN_W'(1);
            end
         end
         ST_FLUSH: if (tv_q == '0 && f_empty) begin
            state_d = ST_FIN;
            irq_d   = 1'b1;
         end
         ST_FIN: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cur_q   <= '0;
         bin_q   <= '0;
         en_q    <= '0;
         done_q  <= '0;
         srv_q   <= '0;
         busy_q  <= 1'b0;
         irq_q   <= 1'b0;
         err_q   <= 1'b0;
         tv_q    <= '0;
         tl_q    <= '0;
         tc_q    <= '{default: '0};
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         bin_q   <= bin_d;
         en_q    <= en_d;
         done_q  <= done_d;
         srv_q   <= srv_d;
         busy_q  <= busy_d;
         irq_q   <= irq_d;
         err_q   <= err_d;
         tv_q    <= tv_d;
         tl_q    <= tl_d;
         tc_q    <= tc_d;
      end
   end

   mrelbp_sync_fifo #(
      .W     (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (f_push),
      .din_i   (f_din),
      .pop_i   (f_pop),
      .dout_o  (f_dout),
      .empty_o (f_empty),
      .full_o  (f_full),
      .count_o (f_cnt)
   );

   a_no_overflow: assert property (
      @(posedge clk) disable iff (rst) !(f_push && f_full));

   assign m_axis_tvalid = !f_empty;
   assign m_axis_tdata  = f_empty ? '0 : f_dout[DATA_W-1:0];
   assign m_axis_tuser  = f_empty ? '0 : f_dout[DATA_W +: CH_W];
   assign m_axis_tlast  = !f_empty && f_dout[FW-1];
   assign busy_o        = busy_q;
   assign irq_o         = irq_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_mrelbp_hist_readout.sv
// Directed bench for mrelbp_hist_readout: histogram model with read
// latency, stream scoreboard, stall/credit monitors.
module tb_mrelbp_hist_readout;
   localparam int NCH = 3;
   localparam int DW  = 32;
   localparam int NB  = 200;
   localparam int LAT = 3;
   localparam int DEP = 4;

   logic              clk = 1'b0;
   logic              rst, start_i;
   logic [NCH-1:0]    ch_en_i, ch_done_i, ch_rd_en_o, ch_valid_i;
   logic [NCH*DW-1:0] ch_data_i;
   logic [DW-1:0]     m_axis_tdata;
   logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic [1:0]        m_axis_tuser;
   logic              busy_o, irq_o, err_o;

   always #5 clk = ~clk;

   mrelbp_hist_readout #(
      .NUM_CH     (NCH),
      .DATA_W     (DW),
      .BINS       (NB),
      .RD_LAT     (LAT),
      .FIFO_DEPTH (DEP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .ch_en_i       (ch_en_i),
      .ch_done_i     (ch_done_i),
      .ch_rd_en_o    (ch_rd_en_o),
      .ch_data_i     (ch_data_i),
      .ch_valid_i    (ch_valid_i),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .busy_o        (busy_o),
      .irq_o         (irq_o),
      .err_o         (err_o)
   );

   int n_run, n_fail;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // histogram memory model: word = bin + (ch << 16), RD_LAT delay
   logic [LAT:0]  pv;
   logic [DW-1:0] pw [LAT+1];
   int            pc [LAT+1];
   int            rdcnt [NCH];

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         ch_data_i[c*DW +: DW] = (pv[LAT] && pc[LAT] == c) ?
                                 pw[LAT] : 32'hDEAD_BEEF;
      end
   end

   logic [DW-1:0]  exp_q [$];
   logic [NCH-1:0] mask_cur;
   int             issued, popped, max_out, beats, irqs;
   bit             rnd_rdy, kill_req, bad_rd, bad_1h, stall_bad, held_v;
   logic [DW+2:0]  held;

   task automatic tick();
      logic [DW-1:0] w;
      @(negedge clk);
      if (rst) begin
         pv     = '0;
         held_v = 1'b0;
      end else begin
         for (int i = LAT; i > 0; i--) begin
            pv[i] = pv[i-1];
            pw[i] = pw[i-1];
            pc[i] = pc[i-1];
         end
         pv[0] = 1'b0;
         for (int c = 0; c < NCH; c++) begin
            if (ch_rd_en_o[c]) begin
               pv[0] = 1'b1;
               pc[0] = c;
               pw[0] = DW'(rdcnt[c] + (c << 16));
               rdcnt[c]++;
            end
         end
         if ($countones(ch_rd_en_o) > 1) bad_1h = 1'b1;
         if ((ch_rd_en_o & ~mask_cur) != '0) bad_rd = 1'b1;
         if (|ch_rd_en_o) issued++;
         ch_valid_i = '1;
         if (kill_req && pv[LAT]) begin
            ch_valid_i = '0;
            kill_req   = 1'b0;
         end
         if (held_v && (!m_axis_tvalid ||
             {m_axis_tlast, m_axis_tuser, m_axis_tdata} !== held))
            stall_bad = 1'b1;
         m_axis_tready = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               chk("extra_beat", 1, 0);
            end else begin
               w = exp_q.pop_front();
               chk("tdata", m_axis_tdata, w);
               chk("tuser", m_axis_tuser, w[17:16]);
               chk("tlast", m_axis_tlast, w[15:0] == 16'(NB - 1));
            end
            beats++;
            popped++;
            held_v = 1'b0;
         end else begin
            held_v = m_axis_tvalid;
         end
         held = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
         if (issued - popped > max_out) max_out = issued - popped;
         if (irq_o) irqs++;
      end
   endtask

   task automatic arm(input logic [NCH-1:0] mask, input bit rnd);
      exp_q.delete();
      for (int c = 0; c < NCH; c++) begin
         rdcnt[c] = 0;
         if (mask[c])
            for (int b = 0; b < NB; b++) exp_q.push_back(DW'(b + (c << 16)));
      end
      issued = 0; popped = 0; max_out = 0; beats = 0; irqs = 0;
      bad_rd = 0; bad_1h = 0; stall_bad = 0;
      mask_cur = mask;
      rnd_rdy  = rnd;
   endtask

   task automatic do_start(input logic [NCH-1:0] mask,
                           input logic [NCH-1:0] pre_done);
      tick();
      start_i   = 1'b1;
      ch_en_i   = mask;
      ch_done_i = pre_done;
      tick();
      start_i   = 1'b0;
      ch_done_i = '0;
      chk("err_clr", err_o, 0);
      chk("busy_on", busy_o, 1);
   endtask

   task automatic pulse_done(input int c);
      ch_done_i = NCH'(1 << c);
      tick();
      ch_done_i = '0;
   endtask

   task automatic wait_irq();
      int n = 0;
      while (irqs == 0 && n < 20000) begin
         tick();
         n++;
      end
      chk("irq_timeout", irqs == 0, 0);
      repeat (5) tick();
   endtask

   task automatic finish_run(input int nexp, input bit exp_err);
      chk("beats", beats, nexp);
      chk("leftover", exp_q.size(), 0);
      chk("irq_cnt", irqs, 1);
      chk("busy_off", busy_o, 0);
      chk("err", err_o, exp_err);
      chk("rd_disabled", bad_rd, 0);
      chk("rd_onehot", bad_1h, 0);
      chk("stall_stable", stall_bad, 0);
      chk("credit", max_out <= DEP, 1);
   endtask

   initial begin
      int n;
      n_run = 0; n_fail = 0;
      rst = 1'b1; start_i = 1'b0; ch_en_i = '0; ch_done_i = '0;
      ch_valid_i = '1; m_axis_tready = 1'b0; kill_req = 1'b0;
      pv = '0; held_v = 1'b0; rnd_rdy = 1'b0; mask_cur = '0;
      arm('0, 0);
      repeat (3) tick();
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_irq", irq_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_rden", ch_rd_en_o, 0);
      rst = 1'b0;
      tick();

      // all channels, done order 2,0,1
      arm(3'b111, 0);
      do_start(3'b111, '0);
      pulse_done(2); pulse_done(0); pulse_done(1);
      wait_irq();
      finish_run(600, 0);

      // channel 1 masked out, its done ignored
      arm(3'b101, 0);
      do_start(3'b101, '0);
      pulse_done(1); pulse_done(2); pulse_done(0);
      wait_irq();
      finish_run(400, 0);

      // random backpressure, done[0] coincident with start
      arm(3'b111, 1);
      do_start(3'b111, 3'b001);
      pulse_done(2); pulse_done(1);
      wait_irq();
      finish_run(600, 0);

      // one tagged word with ch_valid_i low
      arm(3'b111, 0);
      do_start(3'b111, '0);
      pulse_done(0); pulse_done(1); pulse_done(2);
      kill_req = 1'b1;
      wait_irq();
      finish_run(600, 1);

      // empty mask, start during busy ignored
      arm('0, 0);
      tick();
      start_i = 1'b1; ch_en_i = '0;
      tick();
      start_i = 1'b1; ch_en_i = 3'b111;
      chk("z_busy1", busy_o, 1);
      chk("z_irq1", irq_o, 0);
      chk("z_errclr", err_o, 0);
      tick();
      start_i = 1'b0;
      chk("z_irq2", irq_o, 0);
      tick();
      chk("z_irq3", irq_o, 1);
      chk("z_busy3", busy_o, 1);
      tick();
      chk("z_irq4", irq_o, 0);
      chk("z_busy4", busy_o, 0);
      repeat (4) tick();
      chk("z_idle", busy_o, 0);
      chk("z_beats", beats, 0);
      chk("z_irqs", irqs, 1);
      chk("z_rd", bad_rd, 0);

      // reset in the middle of channel 1
      arm(3'b111, 0);
      do_start(3'b111, '0);
      pulse_done(0); pulse_done(1); pulse_done(2);
      n = 0;
      while (beats < 250 && n < 5000) begin
         tick();
         n++;
      end
      chk("abort_reach", beats >= 250, 1);
      rst = 1'b1;
      tick();
      chk("ab_tvalid", m_axis_tvalid, 0);
      chk("ab_rden", ch_rd_en_o, 0);
      chk("ab_busy", busy_o, 0);
      chk("ab_irq", irq_o, 0);
      chk("ab_err", err_o, 0);
      chk("ab_tdata", m_axis_tdata, 0);
      chk("ab_tlast", m_axis_tlast, 0);
      chk("ab_tuser", m_axis_tuser, 0);
      rst = 1'b0;
      tick();
      arm(3'b111, 0);
      do_start(3'b111, '0);
      pulse_done(1); pulse_done(0); pulse_done(2);
      wait_irq();
      finish_run(600, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
